// File: rtl/life_readout_if.sv
// life_readout_if: word stream from life_readout toward the host/bus bridge
//   word_data  [WORD_W]  packed frame bits, LSB = earliest bit (master -> slave)
//   word_valid           word_data/word_last valid, held until accepted (master -> slave)
//   word_last            final word of the frame (master -> slave)
//   word_ready           consumer accepts when valid && ready at a clk edge (slave -> master)
interface life_readout_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              word_last;
    modport master (output word_data, output word_valid, output word_last, input word_ready);
    modport slave  (input word_data, input word_valid, input word_last, output word_ready);
endinterface

// File: rtl/life_readout.sv
// life_readout: captures a cell shift chain and deserializes it into words on a valid/ready stream
//   clk         clock
//   reset       asynchronous active-low reset
//   start       frame request, sampled only while idle
//   busy        high whenever a frame is in progress
//   load_out    one-cycle chain capture strobe
//   shift       one-cycle chain shift strobe per bit advanced
//   chain_in    serial bit from the last cell of the chain
//   wr          word stream (life_readout_if.master)
//   done        one-cycle pulse after the final word is accepted
//   live_count  ones sampled in the current frame (only with READOUT_POPCOUNT_EN defined)
module life_readout #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           load_out,
    output logic           shift,
    input  logic           chain_in,
    life_readout_if.master wr,
    output logic           done
`ifdef READOUT_POPCOUNT_EN
    ,
    output logic [$clog2(CHAIN_LEN+1)-1:0] live_count
`endif
);
    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int WPW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);
    localparam logic [BCW-1:0] FULL     = BCW'(CHAIN_LEN);
    localparam logic [WPW-1:0] LAST_POS = WPW'(WORD_W - 1);

    typedef enum logic [2:0] {IDLE, CAPTURE, SAMPLE, EMIT, DONE} state_t;

    state_t            state, state_nx;
    logic [BCW-1:0]    bitcnt;
    logic [WPW-1:0]    wpos;
    logic [WORD_W-1:0] acc;
    logic              last_bit, word_full, frame_end;

    assign last_bit  = bitcnt == LAST_BIT;
    assign word_full = wpos == LAST_POS;
    // bitcnt saturates at CHAIN_LEN once the final bit has been sampled
    assign frame_end = bitcnt == FULL;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CAPTURE : IDLE;
            CAPTURE: state_nx = SAMPLE;
            SAMPLE:  state_nx = (word_full || last_bit) ? EMIT : SAMPLE;
            EMIT:    state_nx = !wr.word_ready ? EMIT : frame_end ? DONE : SAMPLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // the chain advances in the same cycle a bit is latched, except after the final bit
    assign busy          = state != IDLE;
    assign load_out      = state == CAPTURE;
    assign shift         = state == SAMPLE && !last_bit;
    assign done          = state == DONE;
    assign wr.word_valid = state == EMIT;
    assign wr.word_last  = state == EMIT && frame_end;
    assign wr.word_data  = acc;

    // acc is cleared on acceptance, so unfilled bits of a partial final word read 0
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            bitcnt <= '0;
            wpos   <= '0;
            acc    <= '0;
        end else if (state == CAPTURE) begin
            bitcnt <= '0;
            wpos   <= '0;
            acc    <= '0;
        end else if (state == SAMPLE) begin
            acc[wpos] <= chain_in;
            bitcnt    <= frame_end ? bitcnt : bitcnt + 1'b1;
            wpos      <= word_full ? '0 : wpos + 1'b1;
        end else if (state == EMIT && wr.word_ready) begin
            acc <= '0;
        end

`ifdef READOUT_POPCOUNT_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) live_count <= '0;
        else if (state == CAPTURE) live_count <= '0;
        else if (state == SAMPLE && chain_in) live_count <= live_count + 1'b1;
`endif
endmodule

// File: tb/tb_life_readout.sv
// tb_life_readout: table, random and corner-case checks of two life_readout instances (16 and 12 cells)
module tb_life_readout;
    localparam int NA = 16;
    localparam int NB = 12;

    typedef struct {
        int          i;
        logic [15:0] pat;
        int          mode;
        bit          noise;
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          pop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chain_rst = 1'b1;
    logic [1:0]  start_s = '0;
    logic [1:0]  rdy = '0;
    logic [1:0]  busy, load, shft, cin, done, wval, wlast;
    logic [7:0]  wdat [2];
    logic [15:0] cells [2];
    logic [15:0] snap [2];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_load [2];
    int          n_shift [2];
    int          ng [2];
    int          nd [2];
    int          t0 [2];
    int          dcyc [2];
    int          livec [2];
    logic [7:0]  got_w [2][4];
    logic        got_l [2][4];
    logic [1:0]  pv = '0;
    logic [1:0]  pr = '0;
    logic [1:0]  pl = '0;
    logic [7:0]  pd [2];

    life_readout_if #(.WORD_W(8)) ifa ();
    life_readout_if #(.WORD_W(8)) ifb ();

    assign ifa.word_ready = rdy[0];
    assign ifb.word_ready = rdy[1];
    assign wdat[0]  = ifa.word_data;
    assign wdat[1]  = ifb.word_data;
    assign wval[0]  = ifa.word_valid;
    assign wval[1]  = ifb.word_valid;
    assign wlast[0] = ifa.word_last;
    assign wlast[1] = ifb.word_last;
    assign cin[0]   = snap[0][0];
    assign cin[1]   = snap[1][0];

`ifdef READOUT_POPCOUNT_EN
    logic [4:0] live_a;
    logic [3:0] live_b;
`endif

    life_readout #(.CHAIN_LEN(NA), .WORD_W(8)) dut_a (
        .clk(clk), .reset(rst_n), .start(start_s[0]), .busy(busy[0]), .load_out(load[0]),
        .shift(shft[0]), .chain_in(cin[0]), .wr(ifa), .done(done[0])
`ifdef READOUT_POPCOUNT_EN
        , .live_count(live_a)
`endif
    );

    life_readout #(.CHAIN_LEN(NB), .WORD_W(8)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_s[1]), .busy(busy[1]), .load_out(load[1]),
        .shift(shft[1]), .chain_in(cin[1]), .wr(ifb), .done(done[1])
`ifdef READOUT_POPCOUNT_EN
        , .live_count(live_b)
`endif
    );

    always #5 clk = ~clk;

    // behavioural cell chain: capture on load_out, move one cell toward the reader on shift
    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            snap[i] <= chain_rst ? '0 : load[i] ? cells[i] : shft[i] ? snap[i] >> 1 : snap[i];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        for (int i = 0; i < 2; i++) begin
            if (load[i]) n_load[i]++;
            if (shft[i]) n_shift[i]++;
            if (load[i] || shft[i]) chk($sformatf("dut%0d_strobe_overlap", i), 32'(load[i] & shft[i]), 0);
            if (wval[i]) chk($sformatf("dut%0d_shift_in_emit", i), 32'(shft[i]), 0);
            if (pv[i] && !pr[i]) begin
                chk($sformatf("dut%0d_hold_valid", i), 32'(wval[i]), 1);
                chk($sformatf("dut%0d_hold_data", i), 32'(wdat[i]), 32'(pd[i]));
                chk($sformatf("dut%0d_hold_last", i), 32'(wlast[i]), 32'(pl[i]));
            end
            if (wval[i] && rdy[i]) begin
                if (ng[i] < 4) begin
                    got_w[i][ng[i]] = wdat[i];
                    got_l[i][ng[i]] = wlast[i];
                end
                ng[i]++;
            end
            if (done[i]) begin
                nd[i]++;
                dcyc[i] = cyc;
`ifdef READOUT_POPCOUNT_EN
                livec[i] = (i == 0) ? int'(live_a) : int'(live_b);
`endif
            end
            pv[i] = wval[i];
            pr[i] = rdy[i];
            pd[i] = wdat[i];
            pl[i] = wlast[i];
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [7:0] ref_word(logic [15:0] pat, int n, int k);
        logic [7:0] w = '0;
        for (int b = 0; b < 8; b++)
            if (8 * k + b < n) w[b] = pat[8 * k + b];
        return w;
    endfunction

    function automatic int ref_pop(logic [15:0] pat, int n);
        int c = 0;
        for (int b = 0; b < n; b++) c += int'(pat[b]);
        return c;
    endfunction

    // mode 0: ready high; 1: random ready; 2: ready withheld 5 cycles on word 0
    task automatic run_frame(int i, logic [15:0] pat, int mode, bit noise);
        bit seen = 0;
        int stall = 0;
        cells[i] = pat;
        n_load[i] = 0;
        n_shift[i] = 0;
        ng[i] = 0;
        nd[i] = 0;
        rdy[i] = 1'b1;
        start_s[i] = 1'b1;
        t0[i] = cyc;
        step();
        start_s[i] = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            if (mode == 1) rdy[i] = 1'($urandom_range(0, 1));
            else if (mode == 2 && wval[i] && ng[i] == 0 && stall < 5) begin
                rdy[i] = 1'b0;
                stall++;
            end else rdy[i] = 1'b1;
            start_s[i] = noise && (shft[i] || done[i]);
            seen = done[i];
            step();
        end
        start_s[i] = 1'b0;
        rdy[i] = 1'b1;
        if (!seen) chk($sformatf("dut%0d_done_timeout", i), 0, 1);
        if (mode == 2) chk($sformatf("dut%0d_stall_cycles", i), stall, 5);
        repeat (3) step();
        chk($sformatf("dut%0d_idle_after", i), 32'(busy[i]), 0);
    endtask

    task automatic frame_checks(int i, int n, logic [7:0] e0, logic [7:0] e1, int pop, int mode);
        chk($sformatf("dut%0d_words", i), ng[i], 2);
        chk($sformatf("dut%0d_w0", i), 32'(got_w[i][0]), 32'(e0));
        chk($sformatf("dut%0d_last0", i), 32'(got_l[i][0]), 0);
        chk($sformatf("dut%0d_w1", i), 32'(got_w[i][1]), 32'(e1));
        chk($sformatf("dut%0d_last1", i), 32'(got_l[i][1]), 1);
        chk($sformatf("dut%0d_shifts", i), n_shift[i], n - 1);
        chk($sformatf("dut%0d_loads", i), n_load[i], 1);
        chk($sformatf("dut%0d_dones", i), nd[i], 1);
        if (mode == 0) chk($sformatf("dut%0d_latency", i), dcyc[i] - t0[i], n + 4);
`ifdef READOUT_POPCOUNT_EN
        chk($sformatf("dut%0d_live_count", i), livec[i], pop);
`else
        if (pop < 0) chk("pop_arg", pop, 0);
`endif
    endtask

    task automatic check_quiet(string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_load"}, 32'(load), 0);
        chk({tag, "_shift"}, 32'(shft), 0);
        chk({tag, "_valid"}, 32'(wval), 0);
        chk({tag, "_last"}, 32'(wlast), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_data_a"}, 32'(wdat[0]), 0);
        chk({tag, "_data_b"}, 32'(wdat[1]), 0);
    endtask

    initial begin
        vec_t tbl [6];
        tbl[0] = '{0, 16'h3CA5, 0, 1'b0, 8'hA5, 8'h3C, 8};
        tbl[1] = '{1, 16'h0FFF, 0, 1'b0, 8'hFF, 8'h0F, 12};
        tbl[2] = '{0, 16'h3CA5, 2, 1'b0, 8'hA5, 8'h3C, 8};
        tbl[3] = '{0, 16'h8001, 0, 1'b1, 8'h01, 8'h80, 2};
        tbl[4] = '{1, 16'h00A5, 2, 1'b1, 8'hA5, 8'h00, 4};
        tbl[5] = '{0, 16'hFFFF, 1, 1'b0, 8'hFF, 8'hFF, 16};
        for (int i = 0; i < 2; i++) begin
            cells[i] = '0;
            pd[i] = '0;
            livec[i] = 0;
        end
        step();
        step();
        check_quiet("reset");
        rst_n = 1'b1;
        chain_rst = 1'b0;
        step();

        foreach (tbl[v]) begin
            run_frame(tbl[v].i, tbl[v].pat, tbl[v].mode, tbl[v].noise);
            frame_checks(tbl[v].i, tbl[v].i ? NB : NA, tbl[v].w0, tbl[v].w1, tbl[v].pop, tbl[v].mode);
        end

        for (int r = 0; r < 24; r++) begin
            int i = r % 2;
            int n = i ? NB : NA;
            int mode = int'($urandom_range(0, 1));
            logic [15:0] pat = 16'($urandom);
            if (i == 1) pat[15:12] = '0;
            run_frame(i, pat, mode, 1'b0);
            frame_checks(i, n, ref_word(pat, n, 0), ref_word(pat, n, 1), ref_pop(pat, n), mode);
        end

        begin
            bit hit = 0;
            cells[0] = 16'h3CA5;
            rdy[0] = 1'b0;
            start_s[0] = 1'b1;
            step();
            start_s[0] = 1'b0;
            for (int k = 0; k < 100 && !hit; k++) begin
                hit = wval[0];
                if (!hit) step();
            end
            chk("abort_reached_emit", 32'(hit), 1);
            #2;
            rst_n = 1'b0;
            #1;
            check_quiet("abort");
            pv = '0;
            chain_rst = 1'b1;
            cells[0] = '0;
            step();
            step();
            rst_n = 1'b1;
            chain_rst = 1'b0;
            rdy[0] = 1'b1;
            step();
            run_frame(0, 16'h0000, 0, 1'b0);
            frame_checks(0, NA, 8'h00, 8'h00, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
